// File: rtl/regfile_pkg.sv
// Shared defaults for the register file: data width, select width and depth.
package regfile_pkg;

  // Default register and data-port width.
  localparam int unsigned DATA_W_DEF = 32'd32;

  // Default select width; every select value maps to a real register.
  localparam int unsigned ADDR_W_DEF = 32'd4;

  // Default number of registers, derived so the selects are fully decoded.
  localparam int unsigned DEPTH_DEF  = 32'd1 << ADDR_W_DEF;

endpackage : regfile_pkg

// File: rtl/register_file.sv
// Register file with one write port and two registered read ports.
//
// Writes and reads are both gated by EN.
// A read and a write to the same register in one cycle return the old contents.
// The new value shows up on the next read.
// Read data is registered, so no input reaches Op1/Op2 combinationally.
// The active-low rst clears the storage and both outputs at once, without waiting for clk.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              WR,
  input  logic              RD,
  input  logic [DATA_W-1:0] Ip1,
  input  logic [ADDR_W-1:0] sel_i1,
  input  logic [ADDR_W-1:0] sel_o1,
  input  logic [ADDR_W-1:0] sel_o2,
  output logic [DATA_W-1:0] Op1,
  output logic [DATA_W-1:0] Op2
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_en_s;
  logic              rd_en_s;

  // Qualify the write and read requests with the block enable.
  always_comb begin
    wr_en_s = EN & WR;
    rd_en_s = EN & RD;
  end

  // Storage array: clear on reset, otherwise write the selected register only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[sel_i1] <= Ip1;
    end else begin
      mem_r[sel_i1] <= mem_r[sel_i1];
    end
  end

  // Read registers: capture the pre-write contents, or hold when no read occurs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Op1 <= '0;
      Op2 <= '0;
    end else if (rd_en_s) begin
      Op1 <= mem_r[sel_o1];
      Op2 <= mem_r[sel_o2];
    end else begin
      Op1 <= Op1;
      Op2 <= Op2;
    end
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        EN;
  logic        WR;
  logic        RD;
  logic [31:0] Ip1;
  logic [3:0]  sel_i1;
  logic [3:0]  sel_o1;
  logic [3:0]  sel_o2;
  logic [31:0] Op1;
  logic [31:0] Op2;

  int total = 0;
  int bad   = 0;

  register_file #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .EN     (EN),
    .WR     (WR),
    .RD     (RD),
    .Ip1    (Ip1),
    .sel_i1 (sel_i1),
    .sel_o1 (sel_o1),
    .sel_o2 (sel_o2),
    .Op1    (Op1),
    .Op2    (Op2)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; EN = 1'b0; WR = 1'b0; RD = 1'b0;
    Ip1 = 32'h0; sel_i1 = 4'd0; sel_o1 = 4'd0; sel_o2 = 4'd0;
    #100;
    total++;
    if (Op1 !== 32'h0) begin
      bad++; $display("FAIL reset_op1 got=%h want=%h", Op1, 32'h0);
    end
    total++;
    if (Op2 !== 32'h0) begin
      bad++; $display("FAIL reset_op2 got=%h want=%h", Op2, 32'h0);
    end
    #2 rst = 1'b1;
    tick();
    EN = 1'b1; RD = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sel_o1 = 4'(i);
      sel_o2 = 4'(15 - i);
      tick();
      total++;
      if (Op1 !== 32'h0 || Op2 !== 32'h0) begin
        bad++;
        $display("FAIL reset_readback reg=%0d got=%h/%h want=%h", i, Op1, Op2, 32'h0);
      end
    end
    RD = 1'b0;
  endtask

  task automatic test_write_read();
    EN = 1'b1; WR = 1'b1; RD = 1'b0;
    sel_i1 = 4'd0; Ip1 = 32'hABCD_EFAB; tick();
    sel_i1 = 4'd1; Ip1 = 32'h0123_4567; tick();
    WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd1;
    total++;
    if (Op1 !== 32'h0) begin
      bad++; $display("FAIL read_latency got=%h want=%h", Op1, 32'h0);
    end
    tick();
    total++;
    if (Op1 !== 32'hABCD_EFAB) begin
      bad++; $display("FAIL write_read_op1 got=%h want=%h", Op1, 32'hABCD_EFAB);
    end
    total++;
    if (Op2 !== 32'h0123_4567) begin
      bad++; $display("FAIL write_read_op2 got=%h want=%h", Op2, 32'h0123_4567);
    end
    RD = 1'b0;
  endtask

  task automatic test_enable();
    EN = 1'b0; WR = 1'b1; RD = 1'b0; sel_i1 = 4'd2; Ip1 = 32'hDEAD_BEEF;
    tick();
    EN = 1'b1; WR = 1'b0; RD = 1'b1; sel_o1 = 4'd2; sel_o2 = 4'd0;
    tick();
    total++;
    if (Op1 !== 32'h0) begin
      bad++; $display("FAIL en_blocks_write got=%h want=%h", Op1, 32'h0);
    end
    total++;
    if (Op2 !== 32'hABCD_EFAB) begin
      bad++; $display("FAIL en_read_op2 got=%h want=%h", Op2, 32'hABCD_EFAB);
    end
    EN = 1'b0; RD = 1'b1; sel_o1 = 4'd1; sel_o2 = 4'd1;
    tick();
    total++;
    if (Op1 !== 32'h0 || Op2 !== 32'hABCD_EFAB) begin
      bad++; $display("FAIL en_low_hold got=%h/%h want=%h/%h", Op1, Op2, 32'h0, 32'hABCD_EFAB);
    end
    EN = 1'b1; RD = 1'b0;
    tick();
    total++;
    if (Op1 !== 32'h0 || Op2 !== 32'hABCD_EFAB) begin
      bad++; $display("FAIL rd_low_hold got=%h/%h want=%h/%h", Op1, Op2, 32'h0, 32'hABCD_EFAB);
    end
  endtask

  task automatic test_same_addr();
    EN = 1'b1; WR = 1'b1; RD = 1'b0; sel_i1 = 4'd5; Ip1 = 32'h1111_1111;
    tick();
    RD = 1'b1; sel_o1 = 4'd5; sel_o2 = 4'd5; Ip1 = 32'h2222_2222;
    tick();
    total++;
    if (Op1 !== 32'h1111_1111) begin
      bad++; $display("FAIL rw_same_old got=%h want=%h", Op1, 32'h1111_1111);
    end
    WR = 1'b0;
    tick();
    total++;
    if (Op1 !== 32'h2222_2222) begin
      bad++; $display("FAIL rw_same_new got=%h want=%h", Op1, 32'h2222_2222);
    end
    RD = 1'b0;
  endtask

  task automatic test_back_to_back();
    EN = 1'b1; WR = 1'b1; RD = 1'b1;
    sel_i1 = 4'd3; Ip1 = 32'hA5A5_0003; sel_o1 = 4'd3; sel_o2 = 4'd1;
    tick();
    total++;
    if (Op1 !== 32'h0 || Op2 !== 32'h0123_4567) begin
      bad++; $display("FAIL b2b_first got=%h/%h want=%h/%h", Op1, Op2, 32'h0, 32'h0123_4567);
    end
    sel_i1 = 4'd4; Ip1 = 32'h5A5A_0004; sel_o1 = 4'd3; sel_o2 = 4'd4;
    tick();
    total++;
    if (Op1 !== 32'hA5A5_0003 || Op2 !== 32'h0) begin
      bad++; $display("FAIL b2b_second got=%h/%h want=%h/%h", Op1, Op2, 32'hA5A5_0003, 32'h0);
    end
    WR = 1'b0; sel_o1 = 4'd4; sel_o2 = 4'd2;
    tick();
    total++;
    if (Op1 !== 32'h5A5A_0004 || Op2 !== 32'h0) begin
      bad++; $display("FAIL b2b_third got=%h/%h want=%h/%h", Op1, Op2, 32'h5A5A_0004, 32'h0);
    end
    RD = 1'b0;
  endtask

  task automatic test_top_reg_and_reset();
    EN = 1'b1; WR = 1'b1; RD = 1'b0; sel_i1 = 4'd15; Ip1 = 32'hFFFF_FFFF;
    tick();
    WR = 1'b0; RD = 1'b1; sel_o1 = 4'd15; sel_o2 = 4'd15;
    tick();
    total++;
    if (Op1 !== 32'hFFFF_FFFF || Op2 !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL same_sel got=%h/%h want=%h", Op1, Op2, 32'hFFFF_FFFF);
    end
    // Assert reset between edges while a write is requested.
    WR = 1'b1; sel_i1 = 4'd6; Ip1 = 32'h6666_6666;
    #2 rst = 1'b0;
    #1;
    total++;
    if (Op1 !== 32'h0 || Op2 !== 32'h0) begin
      bad++; $display("FAIL async_reset got=%h/%h want=%h", Op1, Op2, 32'h0);
    end
    tick();
    WR = 1'b0;
    #2 rst = 1'b1;
    sel_o1 = 4'd15; sel_o2 = 4'd5;
    tick();
    total++;
    if (Op1 !== 32'h0 || Op2 !== 32'h0) begin
      bad++; $display("FAIL post_reset_clear got=%h/%h want=%h", Op1, Op2, 32'h0);
    end
    sel_o1 = 4'd6; sel_o2 = 4'd3;
    tick();
    total++;
    if (Op1 !== 32'h0 || Op2 !== 32'h0) begin
      bad++; $display("FAIL write_aborted got=%h/%h want=%h", Op1, Op2, 32'h0);
    end
    RD = 1'b0;
  endtask

  task automatic test_resume();
    rst = 1'b0;
    #3 rst = 1'b1;
    EN = 1'b1; WR = 1'b1; RD = 1'b0; sel_i1 = 4'd7; Ip1 = 32'h7777_0007;
    tick();
    WR = 1'b0; RD = 1'b1; sel_o1 = 4'd7; sel_o2 = 4'd0;
    tick();
    total++;
    if (Op1 !== 32'h7777_0007 || Op2 !== 32'h0) begin
      bad++; $display("FAIL resume got=%h/%h want=%h/%h", Op1, Op2, 32'h7777_0007, 32'h0);
    end
    RD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_enable();
    test_same_addr();
    test_back_to_back();
    test_top_reg_and_reset();
    test_resume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_file
